hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit_if.sv | 44 ++++
 rtl/hazard_control_unit.sv | 98 +++++++++
 tb/tb_hazard_control_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_if.sv
// Decode/execute hazard signals shared between the pipeline (master) and the
// hazard control unit (slave).
interface hazard_control_unit_if #(
  parameter int REGISTER_INDEX_WIDTH = 5,
  parameter int COUNTER_WIDTH        = 16
);
  logic [REGISTER_INDEX_WIDTH-1:0] id_src1_in;
  logic [REGISTER_INDEX_WIDTH-1:0] id_src2_in;
  logic                            id_use_src1_in;
  logic                            id_use_src2_in;
  logic [REGISTER_INDEX_WIDTH-1:0] ex_dst_in;
  logic                            ex_mem_read_in;
  logic                            ex_branch_taken_in;
  logic                            mem_busy_in;

  logic                     pc_write_en_out;
  logic                     fetch_stall_out;
  logic                     decode_stall_out;
  logic                     decode_bubble_out;
  logic                     flush_out;
  logic                     freeze_out;
  logic [1:0]               state_out;
  logic [COUNTER_WIDTH-1:0] stall_cycles_out;
  logic [COUNTER_WIDTH-1:0] flush_count_out;
  logic                     watchdog_error_out;

  // Level signals, no handshake: every input is sampled each cycle and the
  // control outputs respond combinationally within the same cycle.
  modport master (
    output id_src1_in, id_src2_in, id_use_src1_in, id_use_src2_in,
           ex_dst_in, ex_mem_read_in, ex_branch_taken_in, mem_busy_in,
    input  pc_write_en_out, fetch_stall_out, decode_stall_out,
           decode_bubble_out, flush_out, freeze_out, state_out,
           stall_cycles_out, flush_count_out, watchdog_error_out
  );

  modport slave (
    input  id_src1_in, id_src2_in, id_use_src1_in, id_use_src2_in,
           ex_dst_in, ex_mem_read_in, ex_branch_taken_in, mem_busy_in,
    output pc_write_en_out, fetch_stall_out, decode_stall_out,
           decode_bubble_out, flush_out, freeze_out, state_out,
           stall_cycles_out, flush_count_out, watchdog_error_out
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: memory-wait freeze, taken-branch flush, load-use stall,
// plus stall/flush performance counters and a memory-wait watchdog.
module hazard_control_unit #(
  parameter int REGISTER_INDEX_WIDTH = 5,
  parameter int COUNTER_WIDTH        = 16,
  parameter int MAX_WAIT             = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_control_unit_if.slave  hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_t;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1) + 1;
  localparam logic [REGISTER_INDEX_WIDTH-1:0] REG_ZERO = '0;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

  state_t                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] stall_q, flush_cnt_q;
  logic [WAIT_W-1:0]        wait_q;
  logic                     wd_err_q;

  logic load_use;
  logic pc_we, f_stall, d_stall, bubble, flush, freeze;

  assign load_use = hz.ex_mem_read_in && (hz.ex_dst_in != REG_ZERO) &&
                    ((hz.id_use_src1_in && (hz.id_src1_in == hz.ex_dst_in)) ||
                     (hz.id_use_src2_in && (hz.id_src2_in == hz.ex_dst_in)));

  always_comb begin
    state_d = ST_RUN;
    pc_we   = 1'b1;
    f_stall = 1'b0;
    d_stall = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    freeze  = 1'b0;
    // The squashed instruction sitting in decode during FLUSH never stalls.
    if (state_q == ST_FLUSH) bubble = 1'b1;
    if (hz.mem_busy_in) begin
      freeze  = 1'b1;
      f_stall = 1'b1;
      d_stall = 1'b1;
      pc_we   = 1'b0;
      state_d = ST_MEM_WAIT;
    end else if (hz.ex_branch_taken_in) begin
      flush   = 1'b1;
      bubble  = 1'b1;
      state_d = ST_FLUSH;
    end else if (load_use && (state_q != ST_FLUSH)) begin
      f_stall = 1'b1;
      d_stall = 1'b1;
      bubble  = 1'b1;
      pc_we   = 1'b0;
    end
    if (state_q == ST_ILLEGAL) state_d = ST_RUN;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_q     <= '0;
      flush_cnt_q <= '0;
      wait_q      <= '0;
      wd_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (d_stall && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      // Counts cycles spent in MEM_WAIT; the flag trips on the MAX_WAIT-th one.
      if (state_q == ST_MEM_WAIT) begin
        if (wait_q != WAIT_MAX) wait_q <= wait_q + 1'b1;
        if (wait_q >= WAIT_LAST) wd_err_q <= 1'b1;
      end else begin
        wait_q <= '0;
      end
    end
  end

  assign hz.pc_write_en_out    = pc_we;
  assign hz.fetch_stall_out    = f_stall;
  assign hz.decode_stall_out   = d_stall;
  assign hz.decode_bubble_out  = bubble;
  assign hz.flush_out          = flush;
  assign hz.freeze_out         = freeze;
  assign hz.state_out          = state_q;
  assign hz.stall_cycles_out   = stall_q;
  assign hz.flush_count_out    = flush_cnt_q;
  assign hz.watchdog_error_out = wd_err_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: reset checks, a directed vector table, corner
// sequences, and randomized cycles compared against an event-level model.
module tb_hazard_control_unit;
  localparam int RIW  = 5;
  localparam int CW   = 6;
  localparam int MW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst;

  hazard_control_unit_if #(.REGISTER_INDEX_WIDTH(RIW), .COUNTER_WIDTH(CW)) bus ();

  hazard_control_unit #(
    .REGISTER_INDEX_WIDTH(RIW),
    .COUNTER_WIDTH(CW),
    .MAX_WAIT(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus)
  );

  // clock: negedges at 5,15,...; inputs change just after posedge
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  int n_vec;
  int n_fail;

  // reference model state
  bit m_in_flush;
  bit m_in_wait;
  int m_stall;
  int m_flushc;
  int m_wait_run;
  bit m_err;

  logic [5:0] s_ctrl;

  typedef struct {
    bit         busy;
    bit         br;
    bit         mr;
    int         dst;
    int         s1;
    int         s2;
    bit         u1;
    bit         u2;
    logic [5:0] exp_ctrl;   // {pc_we, fetch_stall, decode_stall, bubble, flush, freeze}
    int         exp_state;
  } tv_t;

  tv_t tv[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_state();
    return m_in_wait ? 1 : (m_in_flush ? 2 : 0);
  endfunction

  task automatic model_reset();
    m_in_flush = 0;
    m_in_wait  = 0;
    m_stall    = 0;
    m_flushc   = 0;
    m_wait_run = 0;
    m_err      = 0;
  endtask

  task automatic set_inputs(input bit busy, br, mr, input int dst, s1, s2, input bit u1, u2);
    bus.mem_busy_in        = busy;
    bus.ex_branch_taken_in = br;
    bus.ex_mem_read_in     = mr;
    bus.ex_dst_in          = RIW'(dst);
    bus.id_src1_in         = RIW'(s1);
    bus.id_src2_in         = RIW'(s2);
    bus.id_use_src1_in     = u1;
    bus.id_use_src2_in     = u2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_state", 32'(bus.state_out), 0);
    chk("rst_stall_cnt", 32'(bus.stall_cycles_out), 0);
    chk("rst_flush_cnt", 32'(bus.flush_count_out), 0);
    chk("rst_wd", 32'(bus.watchdog_error_out), 0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  // One pipeline cycle: drive, compare against the model, then advance the model.
  task automatic step(input bit busy, br, mr, input int dst, s1, s2, input bit u1, u2);
    bit hz_m, frz_e, fl_e, lu_e;
    logic [5:0] e;
    @(posedge clk);
    #1;
    set_inputs(busy, br, mr, dst, s1, s2, u1, u2);
    #2;
    hz_m  = mr && (dst != 0) && ((u1 && s1 == dst) || (u2 && s2 == dst));
    frz_e = busy;
    fl_e  = !busy && br;
    lu_e  = !busy && !br && hz_m && !m_in_flush;
    e = {!(frz_e || lu_e), frz_e || lu_e, frz_e || lu_e,
         fl_e || lu_e || m_in_flush, fl_e, frz_e};
    s_ctrl = {bus.pc_write_en_out, bus.fetch_stall_out, bus.decode_stall_out,
              bus.decode_bubble_out, bus.flush_out, bus.freeze_out};
    chk("ctrl", 32'(s_ctrl), 32'(e));
    chk("state", 32'(bus.state_out), model_state());
    chk("stall_cnt", 32'(bus.stall_cycles_out), m_stall);
    chk("flush_cnt", 32'(bus.flush_count_out), m_flushc);
    chk("watchdog", 32'(bus.watchdog_error_out), 32'(m_err));
    @(negedge clk);
    if (frz_e || lu_e) m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
    if (fl_e) m_flushc = (m_flushc == CMAX) ? CMAX : m_flushc + 1;
    if (m_in_wait) begin
      m_wait_run++;
      if (m_wait_run >= MW) m_err = 1;
    end else begin
      m_wait_run = 0;
    end
    m_in_wait  = busy;
    m_in_flush = fl_e;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_use5();
    step(0, 0, 1, 5, 5, 0, 1, 0);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    model_reset();
    rst = 1'b1;
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("init_state", 32'(bus.state_out), 0);
    chk("init_pc_we", 32'(bus.pc_write_en_out), 1);
    chk("init_stall_cnt", 32'(bus.stall_cycles_out), 0);
    #1;
    rst = 1'b0;

    tv[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 0};
    tv[1] = '{1, 0, 0, 0, 0, 0, 0, 0, 6'b011001, 1};
    tv[2] = '{0, 1, 0, 0, 0, 0, 0, 0, 6'b100110, 2};
    tv[3] = '{0, 0, 1, 5, 5, 0, 1, 0, 6'b011100, 0};
    tv[4] = '{0, 0, 1, 0, 0, 0, 1, 0, 6'b100000, 0};
    tv[5] = '{0, 0, 1, 7, 3, 7, 1, 1, 6'b011100, 0};
    tv[6] = '{0, 0, 1, 9, 9, 9, 0, 0, 6'b100000, 0};
    tv[7] = '{0, 0, 0, 4, 4, 0, 1, 0, 6'b100000, 0};
    tv[8] = '{1, 1, 1, 5, 5, 5, 1, 1, 6'b011001, 1};
    tv[9] = '{0, 1, 1, 5, 5, 5, 1, 1, 6'b100110, 2};

    for (int i = 0; i < 10; i++) begin
      do_reset();
      step(tv[i].busy, tv[i].br, tv[i].mr, tv[i].dst, tv[i].s1, tv[i].s2, tv[i].u1, tv[i].u2);
      chk($sformatf("tv%0d_ctrl", i), 32'(s_ctrl), 32'(tv[i].exp_ctrl));
      #1;
      chk($sformatf("tv%0d_next", i), 32'(bus.state_out), tv[i].exp_state);
    end

    // single load-use stall is counted once
    do_reset();
    load_use5();
    chk("lu_ctrl", 32'(s_ctrl), 32'(6'b011100));
    idle();
    chk("lu_ctrl_after", 32'(s_ctrl), 32'(6'b100000));
    chk("lu_stall_cnt", 32'(bus.stall_cycles_out), 1);

    // busy with branch: freeze 3 cycles, then the flush
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0, 0, 0, 0);
      chk("bb_freeze", 32'(s_ctrl), 32'(6'b011001));
    end
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("bb_flush", 32'(s_ctrl), 32'(6'b100110));
    idle();
    chk("bb_flush_cnt", 32'(bus.flush_count_out), 1);
    chk("bb_wd_clear", 32'(bus.watchdog_error_out), 0);

    // watchdog trips and stays set until reset
    do_reset();
    for (int i = 0; i < MW + 2; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    chk("wd_sticky", 32'(bus.watchdog_error_out), 1);
    do_reset();
    idle();
    chk("wd_after_rst", 32'(bus.watchdog_error_out), 0);

    // load-use during FLUSH is ignored
    do_reset();
    step(0, 1, 0, 0, 0, 0, 0, 0);
    load_use5();
    chk("fl_lu_ctrl", 32'(s_ctrl), 32'(6'b100100));
    #1;
    chk("fl_lu_state", 32'(bus.state_out), 0);

    // stall counter saturation
    do_reset();
    for (int i = 0; i < CMAX + 4; i++) load_use5();
    idle();
    chk("stall_sat", 32'(bus.stall_cycles_out), CMAX);

    // reset in the middle of MEM_WAIT and FLUSH
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mw_before_rst", 32'(bus.state_out), 1);
    do_reset();
    idle();
    chk("mw_rst_release", 32'(s_ctrl), 32'(6'b100000));
    step(0, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("fl_before_rst", 32'(bus.state_out), 2);
    do_reset();
    idle();
    chk("fl_rst_release", 32'(s_ctrl), 32'(6'b100000));

    // randomized traffic
    do_reset();
    begin
      bit busy;
      busy = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 199) == 0) do_reset();
        if (busy) busy = ($urandom_range(0, 3) != 0);
        else      busy = ($urandom_range(0, 9) == 0);
        step(busy, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
